// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive path.
//   ps2_state_t  - frame FSM states
//   PS2_PFX_EXT  - extended-key prefix byte (E0)
//   PS2_PFX_BRK  - break (key release) prefix byte (F0)
//   ps2_entry_t  - FIFO entry: scan code plus prefix flags
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] data;
  } ps2_entry_t;

endpackage

// File: rtl/ps2_sync_filt.sv
// ps2_sync_filt: synchroniser, level filter and falling-edge detector for one
// raw PS/2 pin.
// Ports:
//   clk50  - system clock
//   reset  - asynchronous active-low reset (level resets to 1)
//   pin    - raw asynchronous input
//   level  - filtered level; changes only after FILT_LEN consecutive
//            identical synchronised samples
//   fall   - one-cycle pulse when level goes 1->0
// Pin-to-fall latency is SYNC_STAGES+FILT_LEN cycles.
module ps2_sync_filt #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic clk50,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   sample;

  assign sample = sync[SYNC_STAGES-1];

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      sync  <= '1;
      cnt   <= '0;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      fall <= 1'b0;
      // cnt counts consecutive samples that disagree with the current level;
      // any agreeing sample restarts the run.
      if (sample != level) begin
        if (cnt == CW'(FILT_LEN - 1)) begin
          level <= sample;
          cnt   <= '0;
          fall  <= level & ~sample;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with scan-code FIFO.
// Ports:
//   clk50, reset          - system clock, asynchronous active-low reset
//   ps2_clk, ps2_dat      - raw PS/2 pins
//   code_data/ext/brk     - head-of-FIFO entry (first-word-fall-through)
//   code_valid/code_ready - consumer handshake; pop on valid && ready
//   err_parity/frame/timeout - one-cycle, mutually exclusive error pulses
//   overflow              - sticky: good frame dropped on full FIFO
// Build option: define PS2_PREFIX_DECODE_EN to fold E0/F0 prefix bytes into
// the ext/brk flags of the following scan code; otherwise every good byte is
// queued raw and code_ext/code_brk stay 0.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned TIMEOUT_US  = 100,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code_data,
  output logic       code_ext,
  output logic       code_brk,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_timeout,
  output logic       overflow
);

  localparam int unsigned TO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int unsigned TW     = $clog2(TO_CYC);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------- inputs
  logic clk_lvl, clk_fall, dat_lvl, dat_fall_unused;

  ps2_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_clk (
    .clk50(clk50), .reset(reset), .pin(ps2_clk),
    .level(clk_lvl), .fall(clk_fall)
  );

  ps2_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_dat (
    .clk50(clk50), .reset(reset), .pin(ps2_dat),
    .level(dat_lvl), .fall(dat_fall_unused)
  );

  // ------------------------------------------------------------------- FSM
  ps2_state_t  state;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        par_bit;
  logic [TW-1:0] to_cnt;
  logic        push_req;
  ps2_entry_t  push_entry;
`ifdef PS2_PREFIX_DECODE_EN
  logic        ext_pend, brk_pend;
`endif

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      par_bit     <= 1'b0;
      to_cnt      <= '0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      push_req    <= 1'b0;
      push_entry  <= '0;
`ifdef PS2_PREFIX_DECODE_EN
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
`endif
    end else begin
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      push_req    <= 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
      // Flags are dropped the cycle after any error pulse; a good STOP can
      // never land in that cycle, so this cannot race a prefix update below.
      if (err_parity || err_frame || err_timeout) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
`endif
      if (clk_fall) begin
        // A falling edge always restarts the timeout, even in its last cycle.
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_lvl) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              err_frame <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {dat_lvl, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_lvl;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!dat_lvl) begin
              err_frame <= 1'b1;
            end else if (!((^shreg) ^ par_bit)) begin
              err_parity <= 1'b1;
            end else begin
`ifdef PS2_PREFIX_DECODE_EN
              if (shreg == PS2_PFX_EXT) begin
                ext_pend <= 1'b1;
              end else if (shreg == PS2_PFX_BRK) begin
                brk_pend <= 1'b1;
              end else begin
                push_req   <= 1'b1;
                push_entry <= '{ext: ext_pend, brk: brk_pend, data: shreg};
                ext_pend   <= 1'b0;
                brk_pend   <= 1'b0;
              end
`else
              push_req   <= 1'b1;
              push_entry <= '{ext: 1'b0, brk: 1'b0, data: shreg};
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TW'(TO_CYC - 1)) begin
          state       <= IDLE;
          err_timeout <= 1'b1;
          shreg       <= '0;
          to_cnt      <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------ FIFO
  ps2_entry_t    mem [FIFO_DEPTH];
  ps2_entry_t    head;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, pop, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = code_valid && code_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push_req && (!full || pop);

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk50) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign code_valid = !empty;
  assign code_data  = code_valid ? head.data : '0;
  assign code_ext   = code_valid & head.ext;
  assign code_brk   = code_valid & head.brk;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

  localparam int H      = 20;   // PS/2 half period in clk50 cycles
  localparam int TO_CYC = 5000;
  localparam int DEPTH  = 8;

  logic       clk50 = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       code_ready = 1'b0;
  logic [7:0] code_data;
  logic       code_ext, code_brk, code_valid;
  logic       err_parity, err_frame, err_timeout, overflow;

  always #10 clk50 = ~clk50;

  ps2_rx_fifo #(
    .CLK_HZ(50000000), .TIMEOUT_US(100), .FIFO_DEPTH(DEPTH),
    .SYNC_STAGES(2), .FILT_LEN(4)
  ) dut (
    .clk50(clk50), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .code_data(code_data), .code_ext(code_ext), .code_brk(code_brk),
    .code_valid(code_valid), .code_ready(code_ready),
    .err_parity(err_parity), .err_frame(err_frame),
    .err_timeout(err_timeout), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  // Error-pulse observer: counts pulses, flags wide or overlapping pulses.
  int n_par = 0, n_frm = 0, n_to = 0, viol = 0;
  logic p_par = 1'b0, p_frm = 1'b0, p_to = 1'b0;
  always @(negedge clk50) begin
    if (reset) begin
      if (err_parity)  n_par++;
      if (err_frame)   n_frm++;
      if (err_timeout) n_to++;
      if ((err_parity && p_par) || (err_frame && p_frm) || (err_timeout && p_to))
        viol++;
      if (32'(err_parity) + 32'(err_frame) + 32'(err_timeout) > 1) viol++;
      p_par = err_parity;
      p_frm = err_frame;
      p_to  = err_timeout;
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference model: queue of {ext, brk, data} entries in arrival order.
  logic [9:0] exp_q[$];
  int  exp_par = 0, exp_frm = 0, exp_to = 0;
  bit  exp_ovf = 1'b0;
  bit  m_ext = 1'b0, m_brk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [9:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else exp_ovf = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop
  task automatic model_frame(input logic [7:0] b, input int kind);
    if (kind == 1) begin
      exp_par++; m_ext = 0; m_brk = 0;
    end else if (kind == 2) begin
      exp_frm++; m_ext = 0; m_brk = 0;
    end else begin
`ifdef PS2_PREFIX_DECODE_EN
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        model_push({m_ext, m_brk, b});
        m_ext = 0; m_brk = 0;
      end
`else
      model_push({2'b00, b});
`endif
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int kind, input int nbits,
                            input bit glitch, input bit pop_at_stop);
    logic [10:0] bits;
    bits = {kind != 2, (~^b) ^ (kind == 1), b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      if (glitch && i == 5) begin
        repeat (5) @(negedge clk50);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk50);
        ps2_clk = 1'b1;
        repeat (H - 7) @(negedge clk50);
      end else begin
        repeat (H) @(negedge clk50);
      end
      ps2_clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        // stop fall seen after 6 edges, decided on the 7th, written on the 8th
        repeat (7) @(negedge clk50);
        code_ready = 1'b1;
        @(negedge clk50);
        code_ready = 1'b0;
        repeat (H - 8) @(negedge clk50);
      end else begin
        repeat (H) @(negedge clk50);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (H) @(negedge clk50);
  endtask

  task automatic frame(input logic [7:0] b, input int kind);
    model_frame(b, kind);
    send_frame(b, kind, 11, 1'b0, 1'b0);
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s got entry expected none", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".valid"}, 32'(code_valid), 32'd1);
      chk({tag, ".data"},  32'(code_data),  32'(e[7:0]));
      chk({tag, ".ext"},   32'(code_ext),   32'(e[9]));
      chk({tag, ".brk"},   32'(code_brk),   32'(e[8]));
      code_ready = 1'b1;
      @(negedge clk50);
      code_ready = 1'b0;
    end
  endtask

  task automatic drain_all(input string tag);
    while (exp_q.size() > 0) pop_check(tag);
    chk({tag, ".empty"}, 32'(code_valid), 32'd0);
  endtask

  initial begin
    int k, kind, t_el;
    bit seen;
    logic [7:0] rb;

    // reset state
    repeat (5) @(negedge clk50);
    chk("rst.data",  32'(code_data),  32'd0);
    chk("rst.valid", 32'(code_valid), 32'd0);
    chk("rst.ext",   32'(code_ext),   32'd0);
    chk("rst.brk",   32'(code_brk),   32'd0);
    chk("rst.errs",  32'({err_parity, err_frame, err_timeout}), 32'd0);
    chk("rst.ovf",   32'(overflow),   32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk50);

    // single good frame, head held while not ready
    frame(8'h1C, 0);
    chk("t1.valid", 32'(code_valid), 32'd1);
    chk("t1.data",  32'(code_data),  32'h1C);
    repeat (40) @(negedge clk50);
    chk("t1.hold",  32'(code_data),  32'h1C);
    drain_all("t1");
    chk("t1.noerr", 32'(n_par + n_frm + n_to), 32'd0);

    // parity error then good frame
    frame(8'h1C, 1);
    chk("t2.par",   32'(n_par), 32'(exp_par));
    chk("t2.empty", 32'(code_valid), 32'd0);
    frame(8'h32, 0);
    drain_all("t2");

    // timeout: start + 8 data bits, then silence
    exp_to++; m_ext = 0; m_brk = 0;
    send_frame(8'hA5, 0, 9, 1'b0, 1'b0);
    t_el = 2 * H;
    seen = 1'b0;
    while (!seen && t_el < TO_CYC + 200) begin
      if (err_timeout) seen = 1'b1;
      else begin
        @(negedge clk50);
        t_el++;
      end
    end
    // fall seen SYNC+FILT cycles after the pin, then TO_CYC+1 edges to the pulse
    chk("t3.seen",   32'(seen), 32'd1);
    chk("t3.window", 32'(t_el >= TO_CYC + 5 && t_el <= TO_CYC + 9), 32'd1);
    repeat (5) @(negedge clk50);
    chk("t3.count",  32'(n_to), 32'(exp_to));
    frame(8'h1C, 0);
    drain_all("t3");

    // falling clock edge with data high while idle
    exp_frm++; m_ext = 0; m_brk = 0;
    ps2_dat = 1'b1;
    repeat (H) @(negedge clk50);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk50);
    ps2_clk = 1'b1;
    repeat (H) @(negedge clk50);
    chk("t4.frm", 32'(n_frm), 32'(exp_frm));

    // 2-cycle glitch on ps2_clk mid-frame
    model_frame(8'h5A, 0);
    send_frame(8'h5A, 0, 11, 1'b1, 1'b0);
    drain_all("t5");

    // full FIFO with push and pop in the same cycle
    for (int i = 0; i < DEPTH; i++) frame(8'h11 + 8'(i), 0);
    chk("t6.head", 32'(code_data), 32'h11);
    void'(exp_q.pop_front());
    model_frame(8'h19, 0);
    send_frame(8'h19, 0, 11, 1'b0, 1'b1);
    chk("t6.ovf", 32'(overflow), 32'd0);
    drain_all("t6");

    // overflow: nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) frame(8'(i), 0);
    chk("t7.ovf", 32'(overflow), 32'(exp_ovf));
    drain_all("t7");

    // prefix sequence
    frame(8'hE0, 0);
    frame(8'hF0, 0);
    frame(8'h75, 0);
    drain_all("t8");

    // randomized frames
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      k = int'($urandom_range(0, 3));
      kind = (k == 3) ? 1 : (k == 2) ? 2 : 0;
      frame(rb, kind);
    end
    drain_all("t9");

    chk("end.par",  32'(n_par), 32'(exp_par));
    chk("end.frm",  32'(n_frm), 32'(exp_frm));
    chk("end.to",   32'(n_to),  32'(exp_to));
    chk("end.viol", 32'(viol),  32'd0);
    chk("end.ovf",  32'(overflow), 32'(exp_ovf));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
